// File: rtl/multi_tone_detector_if.sv
// Tone qualifier bus: band-pass flags and control in, detection status out.
interface multi_tone_detector_if #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
);
  logic [NUM_CH-1:0] tone_in;
  logic              enable;
  logic              clear;
  logic              det_valid;
  logic [IDX_W-1:0]  det_idx;
  logic              det_pulse;
  logic [7:0]        det_count;
  logic              busy;

  modport master (
    output tone_in, enable, clear,
    input  det_valid, det_idx, det_pulse, det_count, busy
  );

  modport slave (
    input  tone_in, enable, clear,
    output det_valid, det_idx, det_pulse, det_count, busy
  );
endinterface

// File: rtl/multi_tone_detector.sv
// Locks onto the lowest active tone channel, qualifies it with dropout tolerance,
// then holds the detected index for a fixed window before re-arming.
module multi_tone_detector #(
  parameter int NUM_CH        = 4,
  parameter int IDX_W         = 2,
  parameter int CNT_W         = 32,
  parameter int DETECT_CYCLES = 12_500_000,
  parameter int HOLD_CYCLES   = 120_000_000,
  parameter int GAP_TOL       = 0,
  parameter int REARM_EN      = 1
) (
  input logic                  clk,
  input logic                  rst,
  multi_tone_detector_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for enable and any tone
  // QUALIFY | counting high samples of the locked candidate
  // HOLD    | publishing det_idx with det_valid high
  // REARM   | waiting for all tones to drop
  typedef enum logic [1:0] {IDLE, QUALIFY, HOLD, REARM} state_e;

  localparam logic [CNT_W-1:0] DET_C  = CNT_W'(DETECT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TOL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] qual_q, qual_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       count_q, count_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] low_idx;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.tone_in[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    qual_d  = qual_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    pulse_d = 1'b0;
    count_d = count_q;
    if (bus.clear) begin
      state_d = IDLE;
      qual_d  = '0;
      gap_d   = '0;
      hold_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable && (bus.tone_in != '0)) begin
            cand_d = low_idx;
            qual_d = ONE;
            gap_d  = '0;
            if (DET_C == ONE) begin
              state_d = HOLD;
              qual_d  = '0;
              hold_d  = '0;
              valid_d = 1'b1;
              idx_d   = low_idx;
              pulse_d = 1'b1;
              count_d = count_q + 8'd1;
            end else begin
              state_d = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!bus.enable) begin
            state_d = IDLE;
            qual_d  = '0;
            gap_d   = '0;
          end else if (bus.tone_in[cand_q]) begin
            qual_d = qual_q + ONE;
            gap_d  = '0;
            if (qual_q + ONE == DET_C) begin
              state_d = HOLD;
              qual_d  = '0;
              hold_d  = '0;
              valid_d = 1'b1;
              idx_d   = cand_q;
              pulse_d = 1'b1;
              count_d = count_q + 8'd1;
            end
          end else if (gap_q >= GAP_C) begin
            state_d = IDLE;
            qual_d  = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + ONE;
          end
        end
        HOLD: begin
          hold_d = hold_q + ONE;
          if (hold_q + ONE == HOLD_C) begin
            hold_d  = '0;
            valid_d = 1'b0;
            state_d = (REARM_EN != 0) ? REARM : IDLE;
          end
        end
        REARM: begin
          if (bus.tone_in == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      qual_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      qual_q  <= qual_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.det_valid = valid_q;
  assign bus.det_idx   = idx_q;
  assign bus.det_pulse = pulse_q;
  assign bus.det_count = count_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_multi_tone_detector.sv
// Directed bench for multi_tone_detector: scoreboarded detection strobes plus
// per-step state checks on a re-arming and a free-running instance.
module tb_multi_tone_detector;
  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;
  localparam int DET    = 8;
  localparam int HOLD   = 16;
  localparam int GAP    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_cnt_a = '0;
  logic [7:0] exp_cnt_b = '0;

  typedef struct {
    logic [IDX_W-1:0] idx;
    int               at;
    logic [7:0]       cnt;
  } det_t;

  det_t sb_a[$];
  det_t sb_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_tone_detector_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus_a ();
  multi_tone_detector_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus_b ();

  multi_tone_detector #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(32), .DETECT_CYCLES(DET),
    .HOLD_CYCLES(HOLD), .GAP_TOL(GAP), .REARM_EN(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  multi_tone_detector #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(32), .DETECT_CYCLES(DET),
    .HOLD_CYCLES(HOLD), .GAP_TOL(GAP), .REARM_EN(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic push_a(input int idx, input int at);
    det_t e;
    exp_cnt_a = exp_cnt_a + 8'd1;
    e.idx = IDX_W'(idx);
    e.at  = at;
    e.cnt = exp_cnt_a;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int idx, input int at);
    det_t e;
    exp_cnt_b = exp_cnt_b + 8'd1;
    e.idx = IDX_W'(idx);
    e.at  = at;
    e.cnt = exp_cnt_b;
    sb_b.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus_a.det_pulse === 1'b1) begin
      det_t e;
      chk("a_pulse_expected", 32'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_pulse_idx", 32'(bus_a.det_idx), 32'(e.idx));
        chk("a_pulse_cycle", cyc, e.at);
        chk("a_pulse_count", 32'(bus_a.det_count), 32'(e.cnt));
        chk("a_pulse_valid", 32'(bus_a.det_valid), 1);
      end
    end
    if (bus_b.det_pulse === 1'b1) begin
      det_t e;
      chk("b_pulse_expected", 32'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_pulse_idx", 32'(bus_b.det_idx), 32'(e.idx));
        chk("b_pulse_cycle", cyc, e.at);
        chk("b_pulse_count", 32'(bus_b.det_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bus_a.tone_in = '0; bus_a.enable = 1'b0; bus_a.clear = 1'b0;
    bus_b.tone_in = '0; bus_b.enable = 1'b0; bus_b.clear = 1'b0;
    tick(2);
    chk("rst_valid", 32'(bus_a.det_valid), 0);
    chk("rst_idx", 32'(bus_a.det_idx), 0);
    chk("rst_pulse", 32'(bus_a.det_pulse), 0);
    chk("rst_count", 32'(bus_a.det_count), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // 1: basic detection on channel 1, released at edge 10
    c = cyc;
    bus_a.tone_in = 4'b0010; bus_a.enable = 1'b1;
    push_a(1, c + 1 + 7);
    goto(c + 1 + 6);
    chk("t1_valid_e6", 32'(bus_a.det_valid), 0);
    chk("t1_busy_e6", 32'(bus_a.busy), 1);
    goto(c + 1 + 7);
    chk("t1_valid_e7", 32'(bus_a.det_valid), 1);
    goto(c + 1 + 8);
    chk("t1_pulse_e8", 32'(bus_a.det_pulse), 0);
    goto(c + 1 + 9);
    bus_a.tone_in = 4'b0000;
    goto(c + 1 + 22);
    chk("t1_valid_e22", 32'(bus_a.det_valid), 1);
    goto(c + 1 + 23);
    chk("t1_valid_e23", 32'(bus_a.det_valid), 0);
    chk("t1_busy_e23", 32'(bus_a.busy), 1);
    chk("t1_idx_kept", 32'(bus_a.det_idx), 1);
    goto(c + 1 + 24);
    chk("t1_busy_e24", 32'(bus_a.busy), 0);
    chk("t1_count", 32'(bus_a.det_count), 32'(exp_cnt_a));

    // 2a: two-sample dropout after four highs delays detection by two
    c = cyc;
    bus_a.tone_in = 4'b0001;
    goto(c + 1 + 3); bus_a.tone_in = 4'b0000;
    goto(c + 1 + 5); bus_a.tone_in = 4'b0001;
    push_a(0, c + 1 + 9);
    goto(c + 1 + 8);
    chk("t2_valid_e8", 32'(bus_a.det_valid), 0);
    goto(c + 1 + 9);
    chk("t2_valid_e9", 32'(bus_a.det_valid), 1);
    bus_a.tone_in = 4'b0000;
    goto(c + 1 + 27);
    chk("t2_busy_idle", 32'(bus_a.busy), 0);

    // 2b: three-sample dropout aborts qualification
    c = cyc;
    bus_a.tone_in = 4'b0001;
    goto(c + 1 + 3); bus_a.tone_in = 4'b0000;
    goto(c + 1 + 5);
    chk("t2b_busy_e5", 32'(bus_a.busy), 1);
    goto(c + 1 + 6);
    chk("t2b_busy_e6", 32'(bus_a.busy), 0);
    goto(c + 1 + 20);
    chk("t2b_count", 32'(bus_a.det_count), 32'(exp_cnt_a));

    // 3a: two tones, lowest index wins
    c = cyc;
    bus_a.tone_in = 4'b1100;
    push_a(2, c + 1 + 7);
    goto(c + 1 + 7);
    chk("t3_idx", 32'(bus_a.det_idx), 2);
    goto(c + 1 + 9); bus_a.tone_in = 4'b0000;
    goto(c + 1 + 26);

    // 3b: candidate 2 drops mid-qualify; abort, then relock on 3
    c = cyc;
    bus_a.tone_in = 4'b1100;
    goto(c + 1 + 2); bus_a.tone_in = 4'b1000;
    push_a(3, c + 1 + 13);
    goto(c + 1 + 5);
    chk("t3b_abort", 32'(bus_a.busy), 0);
    goto(c + 1 + 6);
    chk("t3b_relock", 32'(bus_a.busy), 1);
    goto(c + 1 + 13);
    chk("t3b_idx", 32'(bus_a.det_idx), 3);
    bus_a.tone_in = 4'b0000;
    goto(c + 1 + 32);

    // 4a: constant tone gives exactly one detection while re-arm is required
    c = cyc;
    bus_a.tone_in = 4'b0100;
    push_a(2, c + 1 + 7);
    goto(c + 1 + 59);
    chk("t4_rearm_busy", 32'(bus_a.busy), 1);
    chk("t4_rearm_valid", 32'(bus_a.det_valid), 0);
    bus_a.tone_in = 4'b0000;
    goto(c + 1 + 61);
    chk("t4_idle", 32'(bus_a.busy), 0);
    chk("t4_count", 32'(bus_a.det_count), 32'(exp_cnt_a));

    // 4b: without re-arm the second strobe lands on edge 31
    c = cyc;
    bus_b.tone_in = 4'b0100; bus_b.enable = 1'b1;
    push_b(2, c + 1 + 7);
    push_b(2, c + 1 + 31);
    goto(c + 1 + 31);
    chk("t4b_valid_e31", 32'(bus_b.det_valid), 1);
    bus_b.tone_in = 4'b0000; bus_b.enable = 1'b0;
    goto(c + 1 + 48);
    chk("t4b_idle", 32'(bus_b.busy), 0);
    chk("t4b_count", 32'(bus_b.det_count), 32'(exp_cnt_b));

    // 5a: clear during hold
    c = cyc;
    bus_a.tone_in = 4'b0010;
    push_a(1, c + 1 + 7);
    goto(c + 1 + 11);
    bus_a.clear = 1'b1;
    goto(c + 1 + 12);
    chk("t5_clear_valid", 32'(bus_a.det_valid), 0);
    chk("t5_clear_busy", 32'(bus_a.busy), 0);
    chk("t5_clear_count", 32'(bus_a.det_count), 32'(exp_cnt_a));
    bus_a.clear = 1'b0; bus_a.tone_in = 4'b0000;
    goto(c + 1 + 14);
    chk("t5_stay_idle", 32'(bus_a.busy), 0);

    // 5b: asynchronous reset mid-qualify
    c = cyc;
    bus_a.tone_in = 4'b0001;
    goto(c + 1 + 3);
    chk("t5b_qualify", 32'(bus_a.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5b_rst_busy", 32'(bus_a.busy), 0);
    chk("t5b_rst_idx", 32'(bus_a.det_idx), 0);
    chk("t5b_rst_count", 32'(bus_a.det_count), 0);
    chk("t5b_rst_valid", 32'(bus_a.det_valid), 0);
    exp_cnt_a = '0;
    exp_cnt_b = '0;
    bus_a.tone_in = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // 6a: enable low with tones present never starts
    bus_a.enable = 1'b0; bus_a.tone_in = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t6_noenable_busy", 32'(bus_a.busy), 0);
    end
    bus_a.tone_in = 4'b0000;

    // 6b: 256 back-to-back detections wrap the counter
    c = cyc;
    bus_b.tone_in = 4'b0001; bus_b.enable = 1'b1;
    for (int i = 0; i < 256; i++) push_b(0, c + 1 + 7 + 24 * i);
    goto(c + 1 + 7 + 24 * 255);
    chk("t6_wrap_count", 32'(bus_b.det_count), 0);
    bus_b.tone_in = 4'b0000; bus_b.enable = 1'b0;
    tick(20);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);
    chk("t6_a_count", 32'(bus_a.det_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_tone_detector.md
Name: multi_tone_detector

Overview:
Parametrised N-channel tone qualifier that sits between the band-pass tone front-end and the navigation/direction logic. It locks onto the lowest-index active tone channel and qualifies it over a programmable persistence window, tolerating short dropouts. It then publishes the detected channel index for a programmable hold window and optionally requires tone release before re-arming. It generalises the fixed four-channel, fixed-count direction detector, adding channel count, glitch tolerance, abort/clear, re-arm mode and a detection counter.

Parameters:
NUM_CH, 4, number of tone channels (>=2)
IDX_W, 2, width of channel index; must satisfy 2**IDX_W >= NUM_CH
CNT_W, 32, width of qualify/hold/gap counters
DETECT_CYCLES, 12_500_000, high samples of candidate required to declare detection (>=1, < 2**CNT_W)
HOLD_CYCLES, 120_000_000, cycles det_valid stays high after detection (>=1, < 2**CNT_W)
GAP_TOL, 0, consecutive low samples of candidate tolerated during qualify (0 = any low aborts)
REARM_EN, 1, 1 = all tones must be low for one cycle before a new qualify may start

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tone_in  input  NUM_CH  per-channel tone-present flags from band-pass stage
enable  input  1  1 = new qualification permitted
clear  input  1  synchronous abort: returns block to IDLE
det_valid  output  1  high while a detection is being held
det_idx  output  IDX_W  channel index of held detection (stable while det_valid)
det_pulse  output  1  one-cycle strobe on the edge det_valid rises
det_count  output  8  total detections since reset, wraps 255->0
busy  output  1  high in QUALIFY, HOLD, REARM

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, det_valid=0, det_idx=0, det_pulse=0, det_count=0, busy=0.
- Priority per edge: reset > clear > enable > state logic. clear=1 in any state -> IDLE next edge, det_valid=0, counters 0; det_count unchanged.
- IDLE: if enable=1 and tone_in!=0 -> candidate := lowest set bit index, qual_cnt:=1, gap_cnt:=0, go QUALIFY. If DETECT_CYCLES=1, go directly to HOLD (detect on this edge).
- QUALIFY: only tone_in[candidate] observed; other channels ignored.
  - enable=0 -> IDLE.
  - candidate high: qual_cnt+1, gap_cnt:=0; when this sample makes qual_cnt==DETECT_CYCLES -> HOLD, det_valid=1, det_idx=candidate, det_pulse=1, det_count+1 (all on same edge).
  - candidate low: qual_cnt holds, gap_cnt+1; if gap_cnt would exceed GAP_TOL -> IDLE, counters 0.
- HOLD: hold_cnt increments each edge from 0; det_pulse=0 after first cycle; on edge where hold_cnt reaches HOLD_CYCLES (det_valid high exactly HOLD_CYCLES cycles) -> det_valid=0, go REARM if REARM_EN else IDLE. enable ignored in HOLD.
- REARM: tone_in==0 on a sampled edge -> IDLE. No detection can start on that same edge.
- det_idx retains last value after det_valid falls; cleared only by reset.
- busy = (state!=IDLE), registered.
- Counters never overflow: compare values bounded by parameters < 2**CNT_W.

Test Plan:
Params NUM_CH=4, DETECT_CYCLES=8, HOLD_CYCLES=16, GAP_TOL=2, REARM_EN=1 unless noted.
1. tone_in=4'b0010 from edge 0, released at edge 10 -> det_valid and det_pulse rise at edge 7, det_idx=1, det_pulse low at edge 8, det_valid falls at edge 23, det_count=1, busy low at edge 24.
2. tone_in=4'b0001 with 2-cycle dropout after 4 high samples -> detection delayed exactly 2 cycles (edge 9). Repeat with 3-cycle dropout -> IDLE, no det_pulse, det_count unchanged.
3. tone_in=4'b1100 constant -> det_idx=2. Switch to 4'b1000 mid-qualify -> candidate 2 low counted as gap; 3 lows abort to IDLE, next qualify locks idx 3.
4. tone held constant 4'b0100 for 60 cycles -> exactly one detection. With REARM_EN=0 -> second det_pulse at edge 24+8-1=31.
5. clear=1 at HOLD cycle 5 -> det_valid=0 next edge, state IDLE. rst=0 asserted mid-QUALIFY -> outputs 0 immediately, without waiting for clk.
6. 256 back-to-back detections -> det_count wraps to 0. enable=0 throughout with tones active -> busy stays 0, no detection.
